// File: rtl/byte_word_assembler_pkg.sv
// rtl/byte_word_assembler_pkg.sv - shared types and address field layout for the byte-to-word assembler
package byte_word_assembler_pkg;

  localparam int LANES     = 4;
  localparam int LANE_W    = 8;
  localparam int REG_IDX_W = 3;
  localparam int ADDR_W    = 5;
  localparam int WORD_W    = LANES * LANE_W;

  localparam int IDX_LSB  = 0;
  localparam int IDX_MSB  = 2;
  localparam int LANE_LSB = 3;
  localparam int LANE_MSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } state_t;

endpackage

// File: rtl/byte_word_assembler_if.sv
// rtl/byte_word_assembler_if.sv - byte-write input, word-write output and error pulse bundle
interface byte_word_assembler_if;
  import byte_word_assembler_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [ADDR_W-1:0]    in_addr;
  logic [LANE_W-1:0]    in_data;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [REG_IDX_W-1:0] wr_reg;
  logic [WORD_W-1:0]    wr_data;
  logic                 err;

  modport master (
    output in_valid, in_addr, in_data, wr_ready,
    input  in_ready, wr_valid, wr_reg, wr_data, err
  );

  modport slave (
    input  in_valid, in_addr, in_data, wr_ready,
    output in_ready, wr_valid, wr_reg, wr_data, err
  );

endinterface

// File: rtl/byte_word_assembler_idle_timer.sv
// rtl/byte_word_assembler_idle_timer.sv - idle cycle counter; expired flags the step that would reach TIMEOUT-1
module idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  assign expired = enable && (count == 8'(TIMEOUT - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/byte_word_assembler.sv
// rtl/byte_word_assembler.sv - gathers four byte lanes for one register index into a 32-bit register-file write
module byte_word_assembler
  import byte_word_assembler_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  byte_word_assembler_if.slave bus
);

  state_t               state_q, state_n;
  logic [LANES-1:0]     mask_q, mask_n;
  logic [REG_IDX_W-1:0] idx_q, idx_n;
  logic [WORD_W-1:0]    data_q, data_n;
  logic                 err_q, err_n;

  logic                 accept;
  logic                 expired;
  logic                 timer_clear;
  logic                 timer_en;
  logic [1:0]           lane;
  logic [REG_IDX_W-1:0] idx;
  logic [LANES-1:0]     lane_bit;

  assign lane     = bus.in_addr[LANE_MSB:LANE_LSB];
  assign idx      = bus.in_addr[IDX_MSB:IDX_LSB];
  assign lane_bit = LANES'(1) << lane;

  assign bus.in_ready = (state_q != ST_WRITE);
  assign bus.wr_valid = (state_q == ST_WRITE);
  assign bus.wr_reg   = idx_q;
  assign bus.wr_data  = data_q;
  assign bus.err      = err_q;

  assign accept = bus.in_valid && bus.in_ready;

  // An accepted byte always beats a coinciding timeout because it disables the count.
  assign timer_en    = (state_q == ST_COLLECT) && !accept;
  assign timer_clear = (state_q != ST_COLLECT) || accept || expired;

  idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_n = state_q;
    mask_n  = mask_q;
    idx_n   = idx_q;
    data_n  = data_q;
    err_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_n  = idx;
          data_n = '0;
          data_n[int'(lane)*LANE_W +: LANE_W] = bus.in_data;
          mask_n  = lane_bit;
          state_n = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (accept && (idx == idx_q)) begin
          data_n[int'(lane)*LANE_W +: LANE_W] = bus.in_data;
          mask_n = mask_q | lane_bit;
          if ((mask_q | lane_bit) == '1) begin
            state_n = ST_WRITE;
          end
        end else if (accept) begin
          err_n  = 1'b1;
          idx_n  = idx;
          data_n = '0;
          data_n[int'(lane)*LANE_W +: LANE_W] = bus.in_data;
          mask_n = lane_bit;
        end else if (expired) begin
          err_n   = 1'b1;
          mask_n  = '0;
          state_n = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (bus.wr_ready) begin
          mask_n  = '0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        mask_n  = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      mask_q  <= mask_n;
      idx_q   <= idx_n;
      data_q  <= data_n;
      err_q   <= err_n;
    end
  end

endmodule

// File: tb/tb_byte_word_assembler.sv
// tb/tb_byte_word_assembler.sv - directed scenarios plus randomized traffic against a behavioural word model
module tb_byte_word_assembler;

  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  byte_word_assembler_if bus ();

  byte_word_assembler #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a partial word is a register number plus a set of seen lanes.
  logic       m_pend   = 1'b0;
  logic       m_active = 1'b0;
  logic       m_err    = 1'b0;
  logic [2:0] m_reg    = '0;
  logic [2:0] m_wreg   = '0;
  logic [31:0] m_word  = '0;
  logic [7:0] m_bytes [4];
  bit         m_have  [4];
  int         m_idle   = 0;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_pend = 1'b0; m_active = 1'b0; m_err = 1'b0; m_idle = 0;
    end else begin
      m_err = 1'b0;
      if (m_pend) begin
        if (bus.wr_ready) m_pend = 1'b0;
      end else if (bus.in_valid) begin
        logic [2:0] r;
        int ln;
        r  = bus.in_addr[2:0];
        ln = int'(bus.in_addr[4:3]);
        if (m_active && r != m_reg) m_err = 1'b1;
        if (!m_active || r != m_reg) begin
          for (int k = 0; k < 4; k++) m_have[k] = 1'b0;
          m_active = 1'b1;
          m_reg    = r;
        end
        m_have[ln]  = 1'b1;
        m_bytes[ln] = bus.in_data;
        m_idle      = 0;
        if (m_have[0] && m_have[1] && m_have[2] && m_have[3]) begin
          m_pend   = 1'b1;
          m_active = 1'b0;
          m_wreg   = m_reg;
          m_word   = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        end
      end else if (m_active) begin
        m_idle++;
        if (m_idle == TIMEOUT - 1) begin
          m_err    = 1'b1;
          m_active = 1'b0;
        end
      end
      chk("model in_ready", bus.in_ready, !m_pend);
      chk("model wr_valid", bus.wr_valid, m_pend);
      chk("model err", bus.err, m_err);
      if (m_pend) begin
        chk("model wr_reg", bus.wr_reg, m_wreg);
        chk("model wr_data", bus.wr_data, m_word);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [2:0] r, input logic [1:0] ln, input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_addr  = {ln, r};
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] target;
    int         lo_rate;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.wr_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset in_ready", bus.in_ready, 1'b1);
    chk("reset wr_valid", bus.wr_valid, 1'b0);
    chk("reset err", bus.err, 1'b0);
    chk("reset wr_reg", bus.wr_reg, 3'd0);
    chk("reset wr_data", bus.wr_data, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // In-order word, register ready.
    send(3'd5, 2'd0, 8'hAA); send(3'd5, 2'd1, 8'hBB);
    send(3'd5, 2'd2, 8'hCC); send(3'd5, 2'd3, 8'hDD);
    chk("inorder wr_valid", bus.wr_valid, 1'b1);
    chk("inorder wr_reg", bus.wr_reg, 3'd5);
    chk("inorder wr_data", bus.wr_data, 32'hDDCCBBAA);
    chk("inorder err", bus.err, 1'b0);
    tick();
    chk("inorder wr_valid drop", bus.wr_valid, 1'b0);

    // Out-of-order lanes with backpressure; a competing byte is offered while held.
    bus.wr_ready = 1'b0;
    send(3'd2, 2'd3, 8'h11); send(3'd2, 2'd1, 8'h22);
    send(3'd2, 2'd0, 8'h33); send(3'd2, 2'd2, 8'h44);
    bus.in_valid = 1'b1; bus.in_addr = {2'd0, 3'd7}; bus.in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      chk("hold in_ready", bus.in_ready, 1'b0);
      chk("hold wr_valid", bus.wr_valid, 1'b1);
      chk("hold wr_reg", bus.wr_reg, 3'd2);
      chk("hold wr_data", bus.wr_data, 32'h11442233);
      if (i < 2) tick();
    end
    bus.in_valid = 1'b0;
    bus.wr_ready = 1'b1;
    tick();
    chk("hold release wr_valid", bus.wr_valid, 1'b0);
    chk("hold release in_ready", bus.in_ready, 1'b1);

    // Index switch discards the partial word, including its lane 0.
    send(3'd1, 2'd0, 8'h99);
    send(3'd4, 2'd1, 8'h55);
    chk("switch err", bus.err, 1'b1);
    tick();
    chk("switch err one cycle", bus.err, 1'b0);
    send(3'd4, 2'd2, 8'h77); send(3'd4, 2'd3, 8'h88);
    chk("switch incomplete", bus.wr_valid, 1'b0);
    send(3'd4, 2'd0, 8'h66);
    chk("switch wr_valid", bus.wr_valid, 1'b1);
    chk("switch wr_reg", bus.wr_reg, 3'd4);
    chk("switch wr_data", bus.wr_data, 32'h88775566);
    tick();

    // Timeout after TIMEOUT-1 idle cycles.
    send(3'd3, 2'd1, 8'h9A);
    for (int i = 1; i <= TIMEOUT - 2; i++) begin
      tick();
      chk("timeout early err", bus.err, 1'b0);
    end
    tick();
    chk("timeout err", bus.err, 1'b1);
    chk("timeout wr_valid", bus.wr_valid, 1'b0);
    tick();
    chk("timeout err clears", bus.err, 1'b0);
    send(3'd3, 2'd0, 8'h01); send(3'd3, 2'd2, 8'h02); send(3'd3, 2'd3, 8'h03);
    chk("timeout mask cleared", bus.wr_valid, 1'b0);
    send(3'd3, 2'd1, 8'h04);
    chk("post-timeout wr_data", bus.wr_data, 32'h03020401);
    tick();

    // Byte arriving on the would-be expiry cycle keeps the word alive.
    send(3'd0, 2'd0, 8'h10);
    for (int i = 1; i <= TIMEOUT - 2; i++) tick();
    send(3'd0, 2'd1, 8'h20);
    chk("race err", bus.err, 1'b0);
    tick();
    chk("race err later", bus.err, 1'b0);
    send(3'd0, 2'd2, 8'h30); send(3'd0, 2'd3, 8'h40);
    chk("race wr_valid", bus.wr_valid, 1'b1);
    chk("race wr_data", bus.wr_data, 32'h40302010);
    tick();

    // Asynchronous reset while a word is pending.
    bus.wr_ready = 1'b0;
    send(3'd7, 2'd0, 8'hA1); send(3'd7, 2'd1, 8'hA2);
    send(3'd7, 2'd2, 8'hA3); send(3'd7, 2'd3, 8'hA4);
    chk("prereset wr_valid", bus.wr_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset wr_valid", bus.wr_valid, 1'b0);
    chk("async reset in_ready", bus.in_ready, 1'b1);
    chk("async reset wr_data", bus.wr_data, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    bus.wr_ready = 1'b1;
    tick();
    chk("after reset err", bus.err, 1'b0);
    send(3'd1, 2'd2, 8'hC3); send(3'd1, 2'd0, 8'hC1);
    send(3'd1, 2'd3, 8'hC4); send(3'd1, 2'd1, 8'hC2);
    chk("after reset wr_reg", bus.wr_reg, 3'd1);
    chk("after reset wr_data", bus.wr_data, 32'hC4C3C2C1);
    tick();

    // Randomized traffic: bursty phases mixed with sparse phases that provoke timeouts.
    target = 3'd0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 60 == 0) target = 3'($urandom_range(0, 7));
      lo_rate = ((i / 300) % 2 == 0) ? 75 : 10;
      bus.in_valid = ($urandom_range(0, 99) < lo_rate);
      bus.in_addr  = {2'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : target};
      bus.in_data  = 8'($urandom);
      bus.wr_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.wr_ready = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_word_assembler.md
BYTE_WORD_ASSEMBLER -- requirements
Module: byte_word_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: idle cycles in COLLECT before a partial word is dropped; legal range 2..255.
REQ-002 SHALL have clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have in_valid, input, 1: a byte write is offered.
REQ-005 SHALL have in_ready, output, 1: the block accepts the offered byte.
REQ-006 SHALL have in_addr, input, 5: [2:0] = register index (0..7), [4:3] = byte lane (0..3); same split as the register-file address separator.
REQ-007 SHALL have in_data, input, 8: byte value.
REQ-008 SHALL have wr_valid, output, 1: assembled word offered to the 8x32 register file.
REQ-009 SHALL have wr_ready, input, 1: the register file takes the word.
REQ-010 SHALL have wr_reg, output, 3: destination register index.
REQ-011 SHALL have wr_data, output, 32: lane k occupies bits [8k+7:8k].
REQ-012 SHALL have err, output, 1: one-cycle pulse when a partial word is discarded.

Function
REQ-013 A byte SHALL be accepted in a cycle where in_valid and in_ready are both 1 at the clock edge; a word SHALL be transferred in a cycle where wr_valid and wr_ready are both 1.
REQ-014 The block SHALL have three states: IDLE, COLLECT and WRITE.
REQ-015 in_ready SHALL be 1 in IDLE and COLLECT and 0 in WRITE; wr_valid SHALL be 1 only in WRITE.
REQ-016 IDLE, byte accepted: latch the register index, write the lane, set lane_mask to that lane's bit only, clear the idle counter, go to COLLECT.
REQ-017 COLLECT, byte accepted with the same register index: write the lane, OR its bit into lane_mask, clear the idle counter; a repeated lane SHALL overwrite its data with lane_mask unchanged.
REQ-018 COLLECT, byte accepted with a different register index: pulse err, discard all lane data, start a new word from this byte as in REQ-016, stay in COLLECT.
REQ-019 When lane_mask reaches 4'hF, the state SHALL become WRITE on the same edge; wr_valid SHALL rise in the cycle after the fourth distinct lane is accepted (latency 1).
REQ-020 Lane bytes SHALL be accepted in any order.
REQ-021 WRITE: wr_reg and wr_data SHALL be held stable while wr_valid=1 and wr_ready=0; on transfer, clear lane_mask and go to IDLE. wr_valid is 0 in the following cycle.
REQ-022 COLLECT, no byte accepted: increment the idle counter; when it reaches TIMEOUT-1, pulse err, clear lane_mask, go to IDLE.
REQ-023 Timeout and a byte accepted in the same cycle: the byte SHALL win; the counter clears and no timeout err is raised. A mismatched-index byte SHALL raise exactly one err pulse.
REQ-024 err SHALL be registered: high for exactly one cycle after the discarding edge.

Reset
REQ-025 While rst_n=0: state=IDLE, lane_mask=0, idle counter=0, wr_reg=0, wr_data=0, wr_valid=0, err=0, in_ready=1. Any partial or pending word is lost without an err pulse.
REQ-026 Reset asserted mid-WRITE SHALL drop wr_valid immediately (asynchronously).

Structure
REQ-027 A shared package SHALL hold the state enum, LANES=4, LANE_W=8, REG_IDX_W=3 and the address field positions.
REQ-028 The idle counter SHALL be a sub-module, idle_timer (clear, enable, expired output, parameter TIMEOUT); everything else stays in one module.

Verification
REQ-029 Bytes AA, BB, CC, DD to register 5, lanes 0..3, back-to-back, wr_ready=1 -> wr_valid one cycle after the last byte, wr_reg=5, wr_data=32'hDDCCBBAA, no err.
REQ-030 Lanes 3,1,0,2 to register 2 with data 11,22,33,44, wr_ready held 0 for 3 cycles -> in_ready=0 and outputs stable for 3 cycles, then transfer of 32'h11442233.
REQ-031 Lane 0 to register 1, then lane 1 to register 4 -> one err pulse; a later full word for register 4 writes correct data with lane 0 from the new bytes only.
REQ-032 One byte, then idle with TIMEOUT=16 -> err in the cycle after the 15th idle cycle, state IDLE, no wr_valid.
REQ-033 A byte arriving in the same cycle as timeout expiry -> no err, collection continues.
REQ-034 rst_n pulsed low during WRITE -> wr_valid falls immediately; after release a fresh 4-byte word assembles correctly.
